// File: rtl/ps2_scan_rx.sv
// rtl/ps2_scan_rx.sv - PS/2 keyboard scan-code receiver with input filtering and prefix stripping
module ps2_scan_rx #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 5000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] code,
  output logic       code_valid,
  output logic       is_break,
  output logic       is_ext,
  output logic [7:0] last_make,
  output logic       frame_err
);

  localparam int WDW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  logic           clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic           filt_q, filt_prev_q;
  logic [7:0]     fcnt_q;
  logic           fall, timeout;

  state_e         state_q, state_d;
  logic [2:0]     bit_q, bit_d;
  logic [7:0]     shift_q, shift_d;
  logic           par_q, par_d;
  logic [WDW-1:0] wd_q, wd_d;
  logic           brk_q, brk_d, ext_q, ext_d;
  logic [7:0]     code_q, code_d, lm_q, lm_d;
  logic           cv_q, cv_d, isb_q, isb_d, ise_q, ise_d, fe_q, fe_d;

  // Synchronise both raw lines and debounce the clock line; idle bus is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_s1_q    <= 1'b1;
      clk_s2_q    <= 1'b1;
      dat_s1_q    <= 1'b1;
      dat_s2_q    <= 1'b1;
      filt_q      <= 1'b1;
      filt_prev_q <= 1'b1;
      fcnt_q      <= '0;
    end else begin
      clk_s1_q    <= ps2_clk;
      clk_s2_q    <= clk_s1_q;
      dat_s1_q    <= ps2_data;
      dat_s2_q    <= dat_s1_q;
      filt_prev_q <= filt_q;
      if (clk_s2_q == filt_q) begin
        fcnt_q <= '0;
      end else if (fcnt_q == 8'(FILTER_LEN - 1)) begin
        filt_q <= clk_s2_q;
        fcnt_q <= '0;
      end else begin
        fcnt_q <= fcnt_q + 8'd1;
      end
    end
  end

  // Falling edge is seen the cycle after the filtered clock drops; watchdog expiry overrides it.
  assign fall    = filt_prev_q & ~filt_q;
  assign timeout = (state_q != S_IDLE) && (wd_q == WDW'(TIMEOUT_CYC));

  // Frame state and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      wd_q    <= '0;
      brk_q   <= 1'b0;
      ext_q   <= 1'b0;
      code_q  <= '0;
      lm_q    <= '0;
      cv_q    <= 1'b0;
      isb_q   <= 1'b0;
      ise_q   <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      wd_q    <= wd_d;
      brk_q   <= brk_d;
      ext_q   <= ext_d;
      code_q  <= code_d;
      lm_q    <= lm_d;
      cv_q    <= cv_d;
      isb_q   <= isb_d;
      ise_q   <= ise_d;
      fe_q    <= fe_d;
    end
  end

  // Deframe on filtered falling edges, evaluate at the stop bit, strip E0/F0 prefixes.
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    wd_d    = '0;
    brk_d   = brk_q;
    ext_d   = ext_q;
    code_d  = code_q;
    lm_d    = lm_q;
    cv_d    = 1'b0;
    isb_d   = isb_q;
    ise_d   = ise_q;
    fe_d    = 1'b0;

    if (state_q != S_IDLE && !fall) begin
      wd_d = wd_q + WDW'(1);
    end

    if (timeout) begin
      fe_d    = 1'b1;
      state_d = S_IDLE;
      brk_d   = 1'b0;
      ext_d   = 1'b0;
    end else if (fall) begin
      case (state_q)
        S_IDLE: begin
          if (!dat_s2_q) begin
            state_d = S_DATA;
            bit_d   = '0;
          end
        end
        S_DATA: begin
          shift_d = {dat_s2_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = S_PARITY;
          end
        end
        S_PARITY: begin
          par_d   = dat_s2_q;
          state_d = S_STOP;
        end
        S_STOP: begin
          state_d = S_IDLE;
          if (!((^shift_q ^ par_q) && dat_s2_q)) begin
            fe_d  = 1'b1;
            brk_d = 1'b0;
            ext_d = 1'b0;
          end else if (shift_q == 8'hE0) begin
            ext_d = 1'b1;
          end else if (shift_q == 8'hF0) begin
            brk_d = 1'b1;
          end else begin
            code_d = shift_q;
            cv_d   = 1'b1;
            isb_d  = brk_q;
            ise_d  = ext_q;
            if (!brk_q) begin
              lm_d = shift_q;
            end
            brk_d = 1'b0;
            ext_d = 1'b0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign code       = code_q;
  assign code_valid = cv_q;
  assign is_break   = isb_q;
  assign is_ext     = ise_q;
  assign last_make  = lm_q;
  assign frame_err  = fe_q;

endmodule
